// File: rtl/tmul_result_collector.sv
// Tags the FMA result stream with a delay-matched issue strobe and packs LANES valid results per tile.
// Latency: tile_valid rises after the edge that captures the LANES-th result (queue empty). Backpressure: 2-entry queue; a push into a full, non-popping queue drops the tile and sets sticky ovf.
// Optional per-lane parity output when TMUL_COLLECT_PARITY_EN is defined.
module tmul_result_collector #(
    parameter int LAT   = 1,
    parameter int LANES = 4,
    parameter int W     = 64,
    localparam int CW   = $clog2(LANES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic [W-1:0]       fma_out,
    input  logic               flush,
    output logic               tile_valid,
    input  logic               tile_ready,
    output logic [LANES*W-1:0] tile_data,
    output logic [CW-1:0]      tile_lanes,
`ifdef TMUL_COLLECT_PARITY_EN
    output logic [LANES-1:0]   tile_parity,
`endif
    output logic               ovf,
    input  logic               clr_ovf
);
    localparam int IW = $clog2(LANES);

    typedef struct packed {
        logic [LANES-1:0][W-1:0] dat;
        logic [CW-1:0]           lanes;
`ifdef TMUL_COLLECT_PARITY_EN
        logic [LANES-1:0]        par;
`endif
    } ent_t;

    typedef enum logic [1:0] {Q_EMPTY, Q_ONE, Q_TWO} q_state_t;

    logic [LAT-1:0]          vpipe;
    logic                    vin;
    logic [IW-1:0]           idx;
    logic [LANES-1:0][W-1:0] pack;
    logic [LANES-1:0][W-1:0] cand;
    logic                    push;
    logic                    pop;
    logic                    accept;
    logic                    drop;
    ent_t                    new_ent;
    ent_t                    head;
    ent_t                    tail;
    q_state_t                state;
    q_state_t                state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= issue_valid;
            for (int i = 1; i < LAT; i++) vpipe[i] <= vpipe[i-1];
        end
    end

    assign vin = vpipe[LAT-1];

    // The tile being pushed already includes a same-cycle result; unfilled lanes stay zero.
    always_comb begin
        cand = pack;
        if (vin) cand[idx] = fma_out;
        push = (vin && (idx == IW'(LANES - 1))) || (flush && ((idx != '0) || vin));
        new_ent       = '0;
        new_ent.dat   = cand;
        new_ent.lanes = CW'(idx) + CW'(vin);
`ifdef TMUL_COLLECT_PARITY_EN
        for (int l = 0; l < LANES; l++) new_ent.par[l] = ^cand[l];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack <= '0;
            idx  <= '0;
        end else if (push) begin
            pack <= '0;
            idx  <= '0;
        end else if (vin) begin
            pack[idx] <= fma_out;
            idx       <= idx + IW'(1);
        end
    end

    assign pop    = (state != Q_EMPTY) && tile_ready;
    assign accept = push && ((state != Q_TWO) || pop);
    assign drop   = push && !accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= Q_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            Q_EMPTY: if (accept) state_nxt = Q_ONE;
            Q_ONE: begin
                if (accept && !pop)      state_nxt = Q_TWO;
                else if (pop && !accept) state_nxt = Q_EMPTY;
            end
            Q_TWO:   if (pop && !accept) state_nxt = Q_ONE;
            default: state_nxt = Q_EMPTY;
        endcase
    end

    always_comb begin
        tile_valid = (state != Q_EMPTY);
        tile_data  = tile_valid ? head.dat : '0;
        tile_lanes = tile_valid ? head.lanes : '0;
`ifdef TMUL_COLLECT_PARITY_EN
        tile_parity = tile_valid ? head.par : '0;
`endif
    end

    // head is the oldest entry; tail only holds data in Q_TWO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            case (state)
                Q_EMPTY: if (accept) head <= new_ent;
                Q_ONE: begin
                    if (accept && pop) head <= new_ent;
                    else if (accept)   tail <= new_ent;
                end
                Q_TWO: begin
                    if (pop) head <= tail;
                    if (accept) tail <= new_ent;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (clr_ovf) ovf <= 1'b0;
    end
endmodule

// File: tb/tb_tmul_result_collector.sv
// Directed bench for tmul_result_collector with LAT=1, LANES=4, W=64.
module tb_tmul_result_collector;
    logic         clk = 1'b0;
    logic         rst;
    logic         issue_valid;
    logic [63:0]  fma_out;
    logic         flush;
    logic         tile_valid;
    logic         tile_ready;
    logic [255:0] tile_data;
    logic [2:0]   tile_lanes;
`ifdef TMUL_COLLECT_PARITY_EN
    logic [3:0]   tile_parity;
`endif
    logic         ovf;
    logic         clr_ovf;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] pat;

    localparam logic [63:0] GARBAGE = 64'hdead_beef_0bad_f00d;

    tmul_result_collector #(.LAT(1), .LANES(4), .W(64)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .fma_out(fma_out),
        .flush(flush), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_data(tile_data), .tile_lanes(tile_lanes),
`ifdef TMUL_COLLECT_PARITY_EN
        .tile_parity(tile_parity),
`endif
        .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [63:0] l0, input logic [63:0] l1,
                                        input logic [63:0] l2, input logic [63:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Issues n operands back to back; result base+i appears one cycle after its issue.
    task automatic stream(input int n, input int base, input logic fl_last, input logic rdy_last);
        issue_valid = 1'b1;
        fma_out     = GARBAGE;
        tick();
        for (int i = 0; i < n; i++) begin
            fma_out = 64'(base + i);
            if (i == n - 1) begin
                issue_valid = 1'b0;
                flush       = fl_last;
                if (rdy_last) tile_ready = 1'b1;
            end
            tick();
        end
        flush   = 1'b0;
        fma_out = GARBAGE;
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; fma_out = GARBAGE; flush = 1'b0;
        tile_ready = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        chk("rst_valid", 256'(tile_valid), 256'(0));
        chk("rst_data",  tile_data, 256'(0));
        chk("rst_lanes", 256'(tile_lanes), 256'(0));
        chk("rst_ovf",   256'(ovf), 256'(0));
        rst = 1'b0;
        tick();

        // Basic full tile, single-cycle valid with ready held high
        tile_ready = 1'b1;
        stream(4, 1, 1'b0, 1'b0);
        chk("full_valid", 256'(tile_valid), 256'(1));
        chk("full_data",  tile_data, mk(64'd1, 64'd2, 64'd3, 64'd4));
        chk("full_lanes", 256'(tile_lanes), 256'(4));
        tick();
        chk("full_one_cycle", 256'(tile_valid), 256'(0));

        // Gapped issue pattern 1,0,1,0,0,1,1; results valid in cycles 1,3,6,7
        pat = 8'b0110_0101;
        for (int c = 0; c < 8; c++) begin
            issue_valid = pat[c];
            fma_out     = 64'(100 + c);
            tick();
        end
        issue_valid = 1'b0;
        chk("gap_valid", 256'(tile_valid), 256'(1));
        chk("gap_data",  tile_data, mk(64'd101, 64'd103, 64'd106, 64'd107));
        tick();
        chk("gap_drained", 256'(tile_valid), 256'(0));

        // Partial flush after two results
        stream(2, 'hA, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("pflush_valid", 256'(tile_valid), 256'(1));
        chk("pflush_data",  tile_data, mk(64'hA, 64'hB, 64'h0, 64'h0));
        chk("pflush_lanes", 256'(tile_lanes), 256'(2));
        tick();
        chk("pflush_drained", 256'(tile_valid), 256'(0));

        // Flush with empty pack is a no-op
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("flush_noop", 256'(tile_valid), 256'(0));

        // Flush coinciding with the first valid result
        stream(1, 'h30, 1'b1, 1'b0);
        chk("flush_vin_lanes", 256'(tile_lanes), 256'(1));
        chk("flush_vin_data",  tile_data, mk(64'h30, 64'h0, 64'h0, 64'h0));
        tick();

        // Flush on natural completion yields exactly one full tile
        stream(4, 5, 1'b1, 1'b0);
        chk("flush_full_lanes", 256'(tile_lanes), 256'(4));
        chk("flush_full_data",  tile_data, mk(64'd5, 64'd6, 64'd7, 64'd8));
        tick();
        chk("flush_full_single", 256'(tile_valid), 256'(0));

        // Backpressure: third tile dropped
        tile_ready = 1'b0;
        stream(12, 1, 1'b0, 1'b0);
        chk("bp_ovf",   256'(ovf), 256'(1));
        chk("bp_head",  tile_data, mk(64'd1, 64'd2, 64'd3, 64'd4));
        tick();
        chk("bp_hold",  tile_data, mk(64'd1, 64'd2, 64'd3, 64'd4));
        tile_ready = 1'b1;
        tick();
        chk("bp_second", tile_data, mk(64'd5, 64'd6, 64'd7, 64'd8));
        tick();
        chk("bp_drained", 256'(tile_valid), 256'(0));
        chk("bp_ovf_sticky", 256'(ovf), 256'(1));
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("bp_ovf_clr", 256'(ovf), 256'(0));

        // Push and pop together while full
        tile_ready = 1'b0;
        stream(8, 21, 1'b0, 1'b0);
        stream(4, 29, 1'b0, 1'b1);
        chk("pp_ovf",   256'(ovf), 256'(0));
        chk("pp_head2", tile_data, mk(64'd25, 64'd26, 64'd27, 64'd28));
        tick();
        chk("pp_head3", tile_data, mk(64'd29, 64'd30, 64'd31, 64'd32));
        tick();
        chk("pp_drained", 256'(tile_valid), 256'(0));

        // Reset in the middle of a pack
        stream(3, 50, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 256'(tile_valid), 256'(0));
        rst = 1'b0;
        tick();
        stream(4, 60, 1'b0, 1'b0);
        chk("post_rst_data",  tile_data, mk(64'd60, 64'd61, 64'd62, 64'd63));
        chk("post_rst_lanes", 256'(tile_lanes), 256'(4));
        chk("post_rst_ovf",   256'(ovf), 256'(0));
        tick();
        chk("post_rst_drained", 256'(tile_valid), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
